fpu_norm_sequencer: RTL and testbench
=====================================

FPU_NORM_SEQUENCER -- requirements
Module: fpu_norm_sequencer

Interface
REQ-001 SHALL have parameter SHIFT_STEP, default 4, meaning the maximum left-shift bits applied per SHIFT cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have parameter MANT_W, default 16, meaning the mantissa width; it is fixed at 16 to match the 16-bit leading-zero detector.
REQ-003 SHALL have parameter EXP_W, default 8, meaning the bfloat16 exponent width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_l, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port flush, input, 1 bit: synchronous abort of any operation in progress.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the request handshake.
REQ-008 SHALL have ports in_mant (input, 16), in_exp (input, 8) and in_sign (input, 1): the unnormalised operand.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the result handshake.
REQ-010 SHALL have ports out_mant (output, 16), out_exp (output, 8), out_sign (output, 1) and out_zero (output, 1): the normalised result.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, DETECT, SHIFT and DONE.
REQ-013 IDLE: in_ready=1; an in_valid&&in_ready cycle latches mant, exp and sign, then moves to DETECT.
REQ-014 DETECT: lzc = leading-zero count of the latched mant (0..16); shift_rem = min(lzc, exp).
REQ-015 DETECT, mant==0: out_zero=1, out_exp=0, out_mant=0, sign kept, move to DONE.
REQ-016 DETECT, mant!=0: shift_rem==0 moves to DONE; otherwise moves to SHIFT.
REQ-017 SHIFT, each cycle: step = min(shift_rem, SHIFT_STEP); mant <<= step; exp -= step; shift_rem -= step.
REQ-018 SHIFT exits to DONE in the cycle shift_rem reaches 0; exp never goes below 0.
REQ-019 DONE: out_valid=1; outputs stay stable until out_valid&&out_ready, then the block returns to IDLE.
REQ-020 A new request is accepted no earlier than the cycle after that return; there is no bypass path.
REQ-021 Latency: accept at cycle T gives out_valid at T+2+ceil(shift/SHIFT_STEP).
REQ-022 flush=1 in any state: IDLE next cycle, out_valid=0, result discarded.
REQ-023 flush SHALL win over a simultaneous output handshake and over a simultaneous input accept.
REQ-024 in_ready=0 in all states except IDLE; in_valid outside IDLE is ignored.

Reset
REQ-025 rst_l low SHALL immediately force state IDLE.
REQ-026 rst_l low SHALL zero out_valid, out_mant, out_exp, out_sign, out_zero and busy; in_ready=1 during and after reset.
REQ-027 Reset in mid-operation SHALL drop the operation with no output produced.

Configuration
REQ-028 Macro FPU_NORM_UNDERFLOW_FLAG_EN defined SHALL add port out_uf (output, 1, reset 0).
REQ-029 out_uf SHALL equal 1 in DONE when lzc > latched exp and mant!=0.
REQ-030 FPU_NORM_UNDERFLOW_FLAG_EN undefined: no port out_uf and no underflow logic; all other behaviour is identical.

Structure
REQ-031 Package fpu_norm_pkg SHALL hold the state enum, the MANT_W/EXP_W constants and the lzc width constant (5).
REQ-032 Leading-zero counting SHALL be in one sub-module, fpu_lzd16: 16-bit input to a 5-bit count plus an all-zero flag, purely combinational.

Verification
REQ-033 Normalised input: mant 0x8000, exp 0x7F, STEP=4 -> out_valid at T+2, mant 0x8000, exp 0x7F, out_zero 0.
REQ-034 Multi-cycle shift: mant 0x0001, exp 0x7F, STEP=4 -> 4 SHIFT cycles, out_valid at T+6, mant 0x8000, exp 0x70.
REQ-035 Zero operand: mant 0x0000, exp 0x40, sign 1 -> out_zero 1, exp 0x00, sign 1, out_valid at T+2.
REQ-036 Underflow (macro on): mant 0x0010, exp 0x05 -> mant 0x0200, exp 0x00, out_uf 1.
REQ-037 Backpressure: out_ready held low 3 cycles in DONE -> outputs unchanged and in_ready stays 0; handshake then IDLE.
REQ-038 Abort cases: rst_l pulsed low mid-SHIFT, and separately flush with out_ready in DONE -> out_valid 0 and IDLE next cycle, in_ready 1.

Source files
------------

// File: rtl/fpu_norm_pkg.sv
// Shared constants and state encoding for the bfloat16 normalisation sequencer
// and its leading-zero detector.
package fpu_norm_pkg;

    localparam int DEF_MANT_W = 16;
    localparam int DEF_EXP_W  = 8;
    localparam int LZC_W      = 5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DETECT = 2'd1;
    localparam state_t ST_SHIFT  = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/fpu_lzd16.sv
// 16-bit leading-zero detector: count of zeros above the highest set bit
// (16 for an all-zero input), purely combinational.
module fpu_lzd16
    import fpu_norm_pkg::*;
(
    input  logic [15:0]      value,
    output logic [LZC_W-1:0] count,
    output logic             all_zero
);

    always_comb begin
        count = 5'd16;
        // Scan upward so the highest set bit is the last one to write count.
        for (int i = 0; i < 16; i++) begin
            if (value[i]) count = 5'(15 - i);
        end
    end

    assign all_zero = (value == 16'h0000);

endmodule

// File: rtl/fpu_norm_sequencer.sv
// Multi-cycle mantissa normaliser: left-shifts by up to SHIFT_STEP bits per cycle,
// clamped at exponent 0. Define FPU_NORM_UNDERFLOW_FLAG_EN to add the out_uf port.
module fpu_norm_sequencer
    import fpu_norm_pkg::*;
#(
    parameter int SHIFT_STEP = 4,
    parameter int MANT_W     = DEF_MANT_W,
    parameter int EXP_W      = DEF_EXP_W
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic              out_zero,
`ifdef FPU_NORM_UNDERFLOW_FLAG_EN
    output logic              out_uf,
`endif
    output logic              busy
);

    localparam logic [LZC_W-1:0] STEP_C = LZC_W'(SHIFT_STEP);

    state_t             state;
    logic [MANT_W-1:0]  mant_q;
    logic [EXP_W-1:0]   exp_q;
    logic               sign_q;
    logic               zero_q;
    logic [LZC_W-1:0]   shift_rem;
    logic [LZC_W-1:0]   lzc;
    logic               mant_is_zero;
    logic [EXP_W-1:0]   lzc_ext;
    logic [LZC_W-1:0]   det_rem;
    logic [LZC_W-1:0]   step;
`ifdef FPU_NORM_UNDERFLOW_FLAG_EN
    logic               uf_q;
`endif

    fpu_lzd16 u_lzd (
        .value    (mant_q),
        .count    (lzc),
        .all_zero (mant_is_zero)
    );

    always_comb begin
        lzc_ext = EXP_W'(lzc);
        // exp_q is below lzc (at most 16) whenever it is chosen, so truncation is safe.
        det_rem = (lzc_ext < exp_q) ? lzc : exp_q[LZC_W-1:0];
        step    = (shift_rem < STEP_C) ? shift_rem : STEP_C;
    end

    // NOTE: every register is updated with <= so all reads in this block see pre-edge values.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= ST_IDLE;
            mant_q    <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            shift_rem <= '0;
`ifdef FPU_NORM_UNDERFLOW_FLAG_EN
            uf_q      <= 1'b0;
`endif
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mant_q <= in_mant;
                        exp_q  <= in_exp;
                        sign_q <= in_sign;
                        zero_q <= 1'b0;
`ifdef FPU_NORM_UNDERFLOW_FLAG_EN
                        uf_q   <= 1'b0;
`endif
                        state  <= ST_DETECT;
                    end
                end
                ST_DETECT: begin
                    if (mant_is_zero) begin
                        zero_q <= 1'b1;
                        mant_q <= '0;
                        exp_q  <= '0;
                        state  <= ST_DONE;
                    end else begin
                        shift_rem <= det_rem;
`ifdef FPU_NORM_UNDERFLOW_FLAG_EN
                        uf_q      <= (lzc_ext > exp_q);
`endif
                        state     <= (det_rem == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    mant_q    <= mant_q << step;
                    exp_q     <= exp_q - EXP_W'(step);
                    shift_rem <= shift_rem - step;
                    if (shift_rem == step) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The working registers double as the result; they are only meaningful while out_valid is high.
    assign out_mant  = mant_q;
    assign out_exp   = exp_q;
    assign out_sign  = sign_q;
    assign out_zero  = zero_q;
    assign out_valid = (state == ST_DONE);
    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
`ifdef FPU_NORM_UNDERFLOW_FLAG_EN
    assign out_uf    = uf_q;
`endif

endmodule

// File: tb/tb_fpu_norm_sequencer.sv
// Directed self-checking bench for fpu_norm_sequencer (SHIFT_STEP = 4); expected
// values are hand-computed. out_uf is checked when FPU_NORM_UNDERFLOW_FLAG_EN is defined.
module tb_fpu_norm_sequencer;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_mant = 16'h0000;
    logic [7:0]  in_exp = 8'h00;
    logic        in_sign = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_sign;
    logic        out_zero;
    logic        busy;
`ifdef FPU_NORM_UNDERFLOW_FLAG_EN
    logic        out_uf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fpu_norm_sequencer #(.SHIFT_STEP(4)) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_sign  (out_sign),
        .out_zero  (out_zero),
`ifdef FPU_NORM_UNDERFLOW_FLAG_EN
        .out_uf    (out_uf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Present one operand; returns just after the accepting edge (cycle T ends there).
    task automatic start_op(input logic [15:0] m, input logic [7:0] e, input logic s);
        @(negedge clk);
        in_mant  = m;
        in_exp   = e;
        in_sign  = s;
        in_valid = 1'b1;
        check("accept_in_ready", 32'(in_ready), 'h1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Latency counted as in T+N: the first negedge after the accept edge is cycle T+1.
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 1;
        int n   = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    // Called at a negedge with out_valid high; completes the output handshake.
    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, 32'(out_valid), 'h0);
        check({tag, "_idle_ready"}, 32'(in_ready), 'h1);
        check({tag, "_idle_busy"}, 32'(busy), 'h0);
    endtask

    initial begin
        logic seen;

        // Reset state, sampled while rst_l is held low
        #12;
        check("rst_out_valid", 32'(out_valid), 'h0);
        check("rst_in_ready", 32'(in_ready), 'h1);
        check("rst_busy", 32'(busy), 'h0);
        check("rst_out_mant", 32'(out_mant), 'h0);
        check("rst_out_exp", 32'(out_exp), 'h0);
        check("rst_out_sign", 32'(out_sign), 'h0);
        check("rst_out_zero", 32'(out_zero), 'h0);
        @(negedge clk);
        rst_l = 1'b1;

        // Already normalised: no SHIFT cycles
        start_op(16'h8000, 8'h7F, 1'b0);
        wait_valid("norm", 2);
        check("norm_mant", 32'(out_mant), 'h8000);
        check("norm_exp", 32'(out_exp), 'h7F);
        check("norm_zero", 32'(out_zero), 'h0);
        check("norm_sign", 32'(out_sign), 'h0);
`ifdef FPU_NORM_UNDERFLOW_FLAG_EN
        check("norm_uf", 32'(out_uf), 'h0);
`endif
        handshake("norm");

        // lzc 15 -> steps 4,4,4,3
        start_op(16'h0001, 8'h7F, 1'b0);
        wait_valid("multi", 6);
        check("multi_mant", 32'(out_mant), 'h8000);
        check("multi_exp", 32'(out_exp), 'h70);
        check("multi_zero", 32'(out_zero), 'h0);
        handshake("multi");

        // Zero operand keeps its sign
        start_op(16'h0000, 8'h40, 1'b1);
        wait_valid("zero", 2);
        check("zero_flag", 32'(out_zero), 'h1);
        check("zero_exp", 32'(out_exp), 'h00);
        check("zero_mant", 32'(out_mant), 'h0000);
        check("zero_sign", 32'(out_sign), 'h1);
        handshake("zero");

        // lzc 11 > exp 5: shift clamped to 5 (steps 4,1)
        start_op(16'h0010, 8'h05, 1'b0);
        wait_valid("uflow", 4);
        check("uflow_mant", 32'(out_mant), 'h0200);
        check("uflow_exp", 32'(out_exp), 'h00);
`ifdef FPU_NORM_UNDERFLOW_FLAG_EN
        check("uflow_uf", 32'(out_uf), 'h1);
`endif
        handshake("uflow");

        // exp already 0: no shift possible
        start_op(16'h0100, 8'h00, 1'b0);
        wait_valid("exp0", 2);
        check("exp0_mant", 32'(out_mant), 'h0100);
        check("exp0_exp", 32'(out_exp), 'h00);
        handshake("exp0");

        // Shift exactly one full step
        start_op(16'h0F00, 8'h20, 1'b0);
        wait_valid("step4", 3);
        check("step4_mant", 32'(out_mant), 'hF000);
        check("step4_exp", 32'(out_exp), 'h1C);
        handshake("step4");

        // Backpressure: 3 cycles with out_ready low and a stray in_valid
        start_op(16'h1234, 8'h10, 1'b1);
        wait_valid("bp", 3);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_mant  = 16'hFFFF;
            in_exp   = 8'h01;
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 'h1);
            check("bp_mant", 32'(out_mant), 'h91A0);
            check("bp_exp", 32'(out_exp), 'h0D);
            check("bp_sign", 32'(out_sign), 'h1);
            check("bp_in_ready", 32'(in_ready), 'h0);
            check("bp_busy", 32'(busy), 'h1);
        end
        in_valid = 1'b0;
        handshake("bp");

        // Reset pulsed mid-SHIFT
        start_op(16'h0001, 8'h7F, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b0;
        #1;
        check("rstmid_valid", 32'(out_valid), 'h0);
        check("rstmid_ready", 32'(in_ready), 'h1);
        check("rstmid_busy", 32'(busy), 'h0);
        check("rstmid_mant", 32'(out_mant), 'h0);
        @(negedge clk);
        rst_l = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("rstmid_no_output", 32'(seen), 'h0);

        // Flush wins over output handshake in DONE
        start_op(16'h8000, 8'h7F, 1'b0);
        wait_valid("flush_done", 2);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        check("flush_done_valid", 32'(out_valid), 'h0);
        check("flush_done_ready", 32'(in_ready), 'h1);
        check("flush_done_busy", 32'(busy), 'h0);

        // Flush wins over input accept in IDLE
        in_mant  = 16'h0001;
        in_exp   = 8'h7F;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_accept_busy", 32'(busy), 'h0);
        check("flush_accept_ready", 32'(in_ready), 'h1);

        // Flush mid-SHIFT
        start_op(16'h0001, 8'h7F, 1'b0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_shift_busy", 32'(busy), 'h0);
        check("flush_shift_valid", 32'(out_valid), 'h0);

        // Normal operation after aborts: lzc 14 -> steps 4,4,4,2
        start_op(16'h0003, 8'h7F, 1'b0);
        wait_valid("post", 6);
        check("post_mant", 32'(out_mant), 'hC000);
        check("post_exp", 32'(out_exp), 'h71);
        handshake("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
